sid_reg_if: RTL

SID_REG_IF -- requirements
Module: sid_reg_if

---
 rtl/sid_pkg.sv | 33 +++
 rtl/sid_strobe_sync.sv | 52 +++++
 rtl/sid_reg_if.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// Shared constants and types for the SID register interface: register
// addresses, filter voice selector, field widths and the arm-state encoding.
package sid_pkg;

  localparam logic [2:0] REG_FREQ_LO = 3'd0;
  localparam logic [2:0] REG_FREQ_HI = 3'd1;
  localparam logic [2:0] REG_PW_LO   = 3'd2;
  localparam logic [2:0] REG_PW_HI   = 3'd3;
  localparam logic [2:0] REG_ATK_DEC = 3'd4;
  localparam logic [2:0] REG_SUS_REL = 3'd5;
  localparam logic [2:0] REG_WAV     = 3'd6;

  localparam logic [2:0] REG_FC_LO    = 3'd0;
  localparam logic [2:0] REG_FC_HI    = 3'd1;
  localparam logic [2:0] REG_RES_FILT = 3'd2;
  localparam logic [2:0] REG_MODE_VOL = 3'd3;

  localparam logic [1:0] VOICE_FILT = 2'd3;

  localparam int NUM_VOICES = 3;
  localparam int FREQ_W     = 16;
  localparam int PW_W       = 12;
  localparam int PW_HI_W    = 4;
  localparam int FC_W       = 11;
  localparam int FC_LO_W    = 3;
  localparam int NIB_W      = 4;

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_state_e;

endpackage

// File: rtl/sid_strobe_sync.sv
// Write-strobe synchroniser, rising-edge detector and arm state machine.
// edge_o is a single-cycle commit request, honoured only once armed.
module sid_strobe_sync
  import sid_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic strobe_sync_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   hist_q;
  arm_state_e             state_q, state_d;

  // vld_q tracks when the chain holds real samples rather than reset zeros,
  // so a strobe held high through reset release is never seen as low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      hist_q  <= 1'b0;
      state_q <= DISARMED;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      hist_q  <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    edge_o  = 1'b0;
    case (state_q)
      DISARMED: begin
        if (vld_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) state_d = ARMED;
      end
      ARMED: begin
        edge_o = sync_q[SYNC_STAGES-1] && !hist_q;
      end
      default: state_d = DISARMED;
    endcase
  end

  assign strobe_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sid_reg_if.sv
// SID-style register file behind a strobed host bus. Define SID_REG_READBACK_EN
// to build the registered readback path; otherwise uio_out/uio_oe are tied to 0.
module sid_reg_if
  import sid_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [FREQ_W-1:0] v_freq    [0:NUM_VOICES-1],
  output logic [PW_W-1:0]   v_pw      [0:NUM_VOICES-1],
  output logic [7:0]        v_atk_dec [0:NUM_VOICES-1],
  output logic [7:0]        v_sus_rel [0:NUM_VOICES-1],
  output logic [7:0]        v_wav     [0:NUM_VOICES-1],
  output logic [FC_W-1:0]   f_fc,
  output logic [NIB_W-1:0]  f_res,
  output logic [NIB_W-1:0]  f_filt,
  output logic [NIB_W-1:0]  f_mode,
  output logic [NIB_W-1:0]  f_vol,
  output logic              wr_pulse,
  output logic [NUM_VOICES-1:0] gate_on,
  output logic [NUM_VOICES-1:0] gate_off
);

  logic       strobe_sync;
  logic       commit;
  logic [1:0] voice_w;
  logic [2:0] addr_w;
  logic       wr_pulse_q;

  assign voice_w = ui_in[4:3];
  assign addr_w  = ui_in[2:0];

  sid_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .strobe_i     (ui_in[7]),
    .strobe_sync_o(strobe_sync),
    .edge_o       (commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_pulse_q <= 1'b0;
    else        wr_pulse_q <= commit;
  end
  assign wr_pulse = wr_pulse_q;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic [7:0]         freq_lo_q, freq_hi_q, pw_lo_q, atk_dec_q, sus_rel_q, wav_q;
    logic [PW_HI_W-1:0] pw_hi_q;
    logic               gate_on_q, gate_off_q;
    logic               sel;

    assign sel = commit && (voice_w == 2'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        freq_lo_q  <= '0;
        freq_hi_q  <= '0;
        pw_lo_q    <= '0;
        pw_hi_q    <= '0;
        atk_dec_q  <= '0;
        sus_rel_q  <= '0;
        wav_q      <= '0;
        gate_on_q  <= 1'b0;
        gate_off_q <= 1'b0;
      end else begin
        gate_on_q  <= 1'b0;
        gate_off_q <= 1'b0;
        if (sel) begin
          case (addr_w)
            REG_FREQ_LO: freq_lo_q <= uio_in;
            REG_FREQ_HI: freq_hi_q <= uio_in;
            REG_PW_LO:   pw_lo_q   <= uio_in;
            REG_PW_HI:   pw_hi_q   <= uio_in[PW_HI_W-1:0];
            REG_ATK_DEC: atk_dec_q <= uio_in;
            REG_SUS_REL: sus_rel_q <= uio_in;
            REG_WAV: begin
              wav_q      <= uio_in;
              gate_on_q  <= uio_in[0] & ~wav_q[0];
              gate_off_q <= ~uio_in[0] & wav_q[0];
            end
            default: ;
          endcase
        end
      end
    end

    assign v_freq[gi]    = {freq_hi_q, freq_lo_q};
    assign v_pw[gi]      = {pw_hi_q, pw_lo_q};
    assign v_atk_dec[gi] = atk_dec_q;
    assign v_sus_rel[gi] = sus_rel_q;
    assign v_wav[gi]     = wav_q;
    assign gate_on[gi]   = gate_on_q;
    assign gate_off[gi]  = gate_off_q;
  end

  logic [FC_LO_W-1:0] fc_lo_q;
  logic [7:0]         fc_hi_q, res_filt_q, mode_vol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_lo_q    <= '0;
      fc_hi_q    <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
    end else if (commit && voice_w == VOICE_FILT) begin
      case (addr_w)
        REG_FC_LO:    fc_lo_q    <= uio_in[FC_LO_W-1:0];
        REG_FC_HI:    fc_hi_q    <= uio_in;
        REG_RES_FILT: res_filt_q <= uio_in;
        REG_MODE_VOL: mode_vol_q <= uio_in;
        default: ;
      endcase
    end
  end

  assign f_fc   = {fc_hi_q, fc_lo_q};
  assign f_res  = res_filt_q[7:4];
  assign f_filt = res_filt_q[3:0];
  assign f_mode = mode_vol_q[7:4];
  assign f_vol  = mode_vol_q[3:0];

`ifdef SID_REG_READBACK_EN
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic [7:0]             rd_byte, uio_out_q, uio_oe_q;
  logic                   rd_active;
  logic                   unused_bits;

  assign unused_bits = ui_in[5];
  assign rd_active   = rd_sync_q[SYNC_STAGES-1] & ~strobe_sync;

  // Readback rebuilds each byte from the stored fields, so discarded bits read 0.
  always_comb begin
    rd_byte = 8'h00;
    if (voice_w == VOICE_FILT) begin
      case (addr_w)
        REG_FC_LO:    rd_byte = {5'b0, f_fc[FC_LO_W-1:0]};
        REG_FC_HI:    rd_byte = f_fc[FC_W-1:FC_LO_W];
        REG_RES_FILT: rd_byte = {f_res, f_filt};
        REG_MODE_VOL: rd_byte = {f_mode, f_vol};
        default:      rd_byte = 8'h00;
      endcase
    end else begin
      case (addr_w)
        REG_FREQ_LO: rd_byte = v_freq[voice_w][7:0];
        REG_FREQ_HI: rd_byte = v_freq[voice_w][15:8];
        REG_PW_LO:   rd_byte = v_pw[voice_w][7:0];
        REG_PW_HI:   rd_byte = {4'b0, v_pw[voice_w][PW_W-1:8]};
        REG_ATK_DEC: rd_byte = v_atk_dec[voice_w];
        REG_SUS_REL: rd_byte = v_sus_rel[voice_w];
        REG_WAV:     rd_byte = v_wav[voice_w];
        default:     rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_q <= '0;
      uio_out_q <= '0;
      uio_oe_q  <= '0;
    end else begin
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], ui_in[6]};
      uio_oe_q  <= rd_active ? 8'hFF : 8'h00;
      uio_out_q <= rd_active ? rd_byte : 8'h00;
    end
  end

  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;
`else
  logic unused_bits;
  assign unused_bits = ^{ui_in[6:5], strobe_sync};
  assign uio_out     = 8'h00;
  assign uio_oe      = 8'h00;
`endif

endmodule
